// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store initiator for word-wide, byte-addressed data memory
// Turns byte/half/word requests into aligned word reads and read-modify-write stores.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES   = 256,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_ready = (state == IDLE);
  // Gated by rst so a reset landing in WR can never corrupt memory.
  assign mem_we    = (state == WR) & ~rst;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ((CHECK_RANGE != 0) && (req_addr >= MEM_LIMIT)) req_err = 1'b1;
  end

  always_comb begin
    rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
      2'b01:   load_data = {{16{rd_half[15] & ~uns_q}}, rd_half};
      default: load_data = mem_rdata;
    endcase
    merge_data = mem_rdata;
    if (size_q == 2'b00) merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            uns_q    <= req_unsigned;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= {req_addr[31:2], 2'b00};
            if (req_err) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && (req_size == 2'b10)) begin
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_wdata <= merge_data;
            state     <= WR;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
// Byte-level reference memory predicts load data, store effects and latencies.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem [64];
  logic        bd_en = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  logic [7:0]  model [256];

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.MEM_BYTES(256), .CHECK_RANGE(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (bd_en) dmem[bd_idx] <= bd_data;
    if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic poke(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = addr[7:2]; bd_data = data;
    for (int i = 0; i < 4; i++) model[8'({addr[7:2], 2'b00} + i)] = data[8*i +: 8];
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  // Reference: little-endian byte memory, alignment/range rules, fixed latencies.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int we_cnt, output logic [31:0] word);
    int n;
    int base;
    longint v;
    n = 1 << size;
    err = (size == 2'd3) || (addr >= 32'd256) || ((addr % n) != 0);
    rdata = '0; we_cnt = 0; word = '0; lat = 1;
    if (err) return;
    base = int'(addr) & ~3;
    if (we) begin
      for (int i = 0; i < n; i++) model[8'(addr + i)] = 8'(wdata >> (8*i));
      lat = (n == 4) ? 2 : 3;
      we_cnt = 1;
      for (int i = 0; i < 4; i++) word[8*i +: 8] = model[8'(base + i)];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(model[8'(addr + i)]) << (8*i);
      if (!uns && n < 4 && v >= (64'sd1 <<< (8*n - 1))) v -= (64'sd1 <<< (8*n));
      rdata = v[31:0];
      lat = 2;
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int we_cnt, output int we_cyc, output logic [31:0] we_data,
                         output logic rdy);
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    lat = -1; rdata = '0; err = 1'b0; we_cnt = 0; we_cyc = -1; we_data = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin we_cnt++; we_cyc = k; we_data = mem_wdata; end
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; break; end
    end
  endtask

  task automatic rand_fields(output logic we, output logic [1:0] size, output logic uns,
                             output logic [31:0] addr, output logic [31:0] wdata);
    int r;
    r = int'($urandom_range(0, 15));
    size = (r == 0) ? 2'd3 : 2'(r % 3);
    we = 1'($urandom_range(0, 1));
    uns = 1'($urandom_range(0, 1));
    r = int'($urandom_range(0, 19));
    if (r == 0)      addr = 32'hFFFF_FFFC;
    else if (r == 1) addr = 32'h100 + $urandom_range(0, 64);
    else             addr = $urandom_range(0, 255);
    wdata = $urandom;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we_during: got %b expected 0", mem_we); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
  endtask

  typedef struct {
    logic        poke; logic [31:0] pword;
    logic        we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; logic exp_err; int exp_lat; logic [31:0] exp_word;
  } dir_t;

  task automatic test_directed;
    dir_t tbl [13];
    int lat, we_cnt, we_cyc, mlat, mcnt;
    logic [31:0] rdata, we_data, mrd, mword;
    logic err, rdy, merr;
    tbl[0]  = '{1'b1, 32'h12345678, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0, 2, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h00000012, 1'b0, 2, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'h00001234, 1'b0, 2, 32'h0};
    tbl[3]  = '{1'b1, 32'h1234F078, 1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFFF0, 1'b0, 2, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h000000F0, 1'b0, 2, 32'h0};
    tbl[5]  = '{1'b1, 32'h12345678, 1'b1, 2'd0, 1'b0, 32'h12,  32'h000000AB, 32'h0,        1'b0, 3, 32'h12AB5678};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 2'd1, 1'b0, 32'h10,  32'h0000BEEF, 32'h0,        1'b0, 3, 32'h12ABBEEF};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12ABBEEF, 1'b0, 2, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 2'd2, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 2'd1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 32'h0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h14,  32'hCAFEBABE, 32'h0,        1'b0, 2, 32'hCAFEBABE};
    foreach (tbl[i]) begin
      if (tbl[i].poke) poke(8'h10, tbl[i].pword);
      model_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, mlat, mrd, merr, mcnt, mword);
      run_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
              lat, rdata, err, we_cnt, we_cyc, we_data, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL dir%0d_ready: got %b expected 1", i, rdy); end
      checks++; if (lat != tbl[i].exp_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tbl[i].exp_lat); end
      checks++; if (rdata !== tbl[i].exp_rdata) begin errors++; $display("FAIL dir%0d_rdata: got %h expected %h", i, rdata, tbl[i].exp_rdata); end
      checks++; if (err !== tbl[i].exp_err) begin errors++; $display("FAIL dir%0d_err: got %b expected %b", i, err, tbl[i].exp_err); end
      checks++;
      if (we_cnt != ((tbl[i].we && !tbl[i].exp_err) ? 1 : 0)) begin
        errors++; $display("FAIL dir%0d_we_count: got %0d expected %0d", i, we_cnt, (tbl[i].we && !tbl[i].exp_err) ? 1 : 0);
      end
      if (tbl[i].we && !tbl[i].exp_err) begin
        checks++; if (we_data !== tbl[i].exp_word) begin errors++; $display("FAIL dir%0d_we_data: got %h expected %h", i, we_data, tbl[i].exp_word); end
        checks++; if (we_cyc != tbl[i].exp_lat - 1) begin errors++; $display("FAIL dir%0d_we_cycle: got %0d expected %0d", i, we_cyc, tbl[i].exp_lat - 1); end
      end
    end
  endtask

  task automatic test_random;
    logic we, uns, err, rdy, merr;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata, we_data, mrd, mword;
    int lat, we_cnt, we_cyc, mlat, mcnt;
    for (int n = 0; n < 150; n++) begin
      rand_fields(we, size, uns, addr, wdata);
      model_req(we, size, uns, addr, wdata, mlat, mrd, merr, mcnt, mword);
      run_req(we, size, uns, addr, wdata, lat, rdata, err, we_cnt, we_cyc, we_data, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %b expected 1", n, rdy); end
      checks++; if (lat != mlat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d (we=%b size=%0d addr=%h)", n, lat, mlat, we, size, addr); end
      checks++; if (rdata !== mrd) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h (we=%b size=%0d uns=%b addr=%h)", n, rdata, mrd, we, size, uns, addr); end
      checks++; if (err !== merr) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b (size=%0d addr=%h)", n, err, merr, size, addr); end
      checks++; if (we_cnt != mcnt) begin errors++; $display("FAIL rnd%0d_we_count: got %0d expected %0d", n, we_cnt, mcnt); end
      if (mcnt == 1) begin
        checks++; if (we_data !== mword) begin errors++; $display("FAIL rnd%0d_we_data: got %h expected %h (size=%0d addr=%h)", n, we_data, mword, size, addr); end
      end
    end
    for (int w = 0; w < 64; w++) begin
      logic [31:0] expw;
      for (int b = 0; b < 4; b++) expw[8*b +: 8] = model[8'(4*w + b)];
      checks++; if (dmem[w] !== expw) begin errors++; $display("FAIL rnd_mem_word%0d: got %h expected %h", w, dmem[w], expw); end
    end
  endtask

  task automatic test_reset_during_wr;
    logic saw_resp;
    poke(8'h20, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rwr_in_wr: got %b expected 1", mem_we); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rwr_we_gated: got %b expected 0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rwr_ready: got %b expected 1", req_ready); end
    saw_resp = resp_valid;
    repeat (4) begin @(negedge clk); saw_resp |= resp_valid; end
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL rwr_no_resp: got %b expected 0", saw_resp); end
    checks++; if (dmem[8] !== 32'hCAFEF00D) begin errors++; $display("FAIL rwr_mem_unchanged: got %h expected %h", dmem[8], 32'hCAFEF00D); end
  endtask

  task automatic test_back_to_back;
    localparam int N = 8;
    int acc_cyc [N];
    int exp_lat [N];
    logic [31:0] exp_rd [N];
    logic exp_er [N];
    int nacc, nresp, cyc, mcnt;
    logic acc, merr, we, uns;
    logic [1:0] size;
    logic [31:0] addr, wdata, mrd, mword;
    nacc = 0; nresp = 0; cyc = 0;
    @(negedge clk);
    rand_fields(we, size, uns, addr, wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (cyc < 100 && nresp < N) begin
      acc = req_valid && req_ready;
      @(negedge clk);
      cyc++;
      if (acc) begin
        model_req(req_we, req_size, req_unsigned, req_addr, req_wdata,
                  exp_lat[nacc], exp_rd[nacc], exp_er[nacc], mcnt, mword);
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (resp_valid) begin
        checks++; if (resp_rdata !== exp_rd[nresp]) begin errors++; $display("FAIL b2b%0d_rdata: got %h expected %h", nresp, resp_rdata, exp_rd[nresp]); end
        checks++; if (resp_err !== exp_er[nresp]) begin errors++; $display("FAIL b2b%0d_err: got %b expected %b", nresp, resp_err, exp_er[nresp]); end
        checks++; if (cyc - acc_cyc[nresp] + 1 != exp_lat[nresp]) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", nresp, cyc - acc_cyc[nresp] + 1, exp_lat[nresp]); end
        nresp++;
      end
      // Fields are re-randomized every cycle; only the values present at acceptance matter.
      if (nacc < N) begin
        rand_fields(we, size, uns, addr, wdata);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (nresp != N) begin errors++; $display("FAIL b2b_resp_count: got %0d expected %0d", nresp, N); end
    for (int i = 0; i + 1 < nacc; i++) begin
      checks++;
      if (acc_cyc[i+1] - acc_cyc[i] != exp_lat[i] + 1) begin
        errors++; $display("FAIL b2b%0d_accept_gap: got %0d expected %0d", i, acc_cyc[i+1] - acc_cyc[i], exp_lat[i] + 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    for (int w = 0; w < 64; w++) poke(8'(4*w), $urandom);
    test_directed();
    test_random();
    test_reset_during_wr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
